// File: rtl/mips_control_unit.sv
// mips_control_unit
//   Multicycle control FSM for the enhanced MIPS core. It sequences fetch,
//   decode, execute and writeback. It also drives the instruction unit, the
//   register file, the ALU and the data memory.
// Ports
//   clk, reset          : clock and async active-high reset
//   ir                  : instruction register contents (stable outside FETCH)
//   alu_z               : ALU zero flag, consumed in BR_CMP
//   pc_sel/pc_ld/pc_inc : PC source select, PC load, PC+4
//   ir_ld, im_cs, im_rd : instruction fetch controls
//   rf_wr/rf_dsel/wb_sel: register write enable, address select, data select
//   b_sel, alu_fs       : ALU operand B select and function
//   dm_cs/dm_rd/dm_wr   : data memory controls
//   halted, illegal     : sticky terminal status
module mips_control_unit #(
    parameter logic [4:0] RA_REG     = 5'd31,
    parameter int          RESET_HOLD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        alu_z,
    output logic [1:0]  pc_sel,
    output logic        pc_ld,
    output logic        pc_inc,
    output logic        ir_ld,
    output logic        im_cs,
    output logic        im_rd,
    output logic        rf_wr,
    output logic [1:0]  rf_dsel,
    output logic [1:0]  wb_sel,
    output logic        b_sel,
    output logic [3:0]  alu_fs,
    output logic        dm_cs,
    output logic        dm_rd,
    output logic        dm_wr,
    output logic        halted,
    output logic        illegal
);

    localparam logic [4:0] S_RESET   = 5'd0,  S_FETCH   = 5'd1,  S_DECODE  = 5'd2,
                           S_R_EXEC  = 5'd3,  S_R_WB    = 5'd4,  S_I_EXEC  = 5'd5,
                           S_I_WB    = 5'd6,  S_LW_ADDR = 5'd7,  S_LW_RD   = 5'd8,
                           S_LW_WB   = 5'd9,  S_SW_ADDR = 5'd10, S_SW_WR   = 5'd11,
                           S_BR_CMP  = 5'd12, S_BR_TAKE = 5'd13, S_J       = 5'd14,
                           S_JAL     = 5'd15, S_JR      = 5'd16, S_HALT    = 5'd17,
                           S_ILLEGAL = 5'd18;

    localparam logic [3:0] FS_PASS = 4'b0000, FS_ADD = 4'b0010, FS_SUB = 4'b0011,
                           FS_SLT  = 4'b0110, FS_AND = 4'b1000, FS_OR  = 4'b1001;

    localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    logic [4:0]    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;

    logic [5:0] op, fn;
    logic [3:0] r_fs;
    logic       r_ok;

    assign op = ir[31:26];
    assign fn = ir[5:0];

    // Register fields and the return-address index are consumed by the
    // datapath, not by the sequencer.
    logic unused_ok;
    assign unused_ok = ^{ir[25:6], RA_REG};

    // R-type funct decode, shared by DECODE dispatch and R_EXEC/R_WB.
    always_comb begin
        r_ok = 1'b1;
        r_fs = FS_ADD;
        case (fn)
            6'h20:   r_fs = FS_ADD;
            6'h22:   r_fs = FS_SUB;
            6'h24:   r_fs = FS_AND;
            6'h25:   r_fs = FS_OR;
            6'h2A:   r_fs = FS_SLT;
            default: r_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            S_RESET: begin
                if (hold_q == HW'(RESET_HOLD - 1)) state_d = S_FETCH;
                else                               hold_d  = hold_q + 1'b1;
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    6'h00: begin
                        if (r_ok)            state_d = S_R_EXEC;
                        else if (fn == 6'h08) state_d = S_JR;
                        else if (fn == 6'h0D) state_d = S_HALT;
                        else                 state_d = S_ILLEGAL;
                    end
                    6'h08:        state_d = S_I_EXEC;
                    6'h23:        state_d = S_LW_ADDR;
                    6'h2B:        state_d = S_SW_ADDR;
                    6'h04, 6'h05: state_d = S_BR_CMP;
                    6'h02:        state_d = S_J;
                    6'h03:        state_d = S_JAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_R_EXEC:  state_d = S_R_WB;
            S_I_EXEC:  state_d = S_I_WB;
            S_LW_ADDR: state_d = S_LW_RD;
            S_LW_RD:   state_d = S_LW_WB;
            S_SW_ADDR: state_d = S_SW_WR;
            // op[0] distinguishes bne (05) from beq (04).
            S_BR_CMP:  state_d = (alu_z ^ op[0]) ? S_BR_TAKE : S_FETCH;
            S_HALT:    state_d = S_HALT;
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore outputs; RESET decodes to all zeros, so async reset clears them at once.
    always_comb begin
        pc_sel  = 2'b00; pc_ld  = 1'b0; pc_inc = 1'b0; ir_ld = 1'b0;
        im_cs   = 1'b0;  im_rd  = 1'b0; rf_wr  = 1'b0; rf_dsel = 2'b00;
        wb_sel  = 2'b00; b_sel  = 1'b0; alu_fs = FS_PASS;
        dm_cs   = 1'b0;  dm_rd  = 1'b0; dm_wr  = 1'b0;
        halted  = 1'b0;  illegal = 1'b0;
        case (state_q)
            S_FETCH: begin
                im_cs = 1'b1; im_rd = 1'b1; ir_ld = 1'b1; pc_inc = 1'b1;
            end
            S_R_EXEC: alu_fs = r_fs;
            S_R_WB: begin
                alu_fs = r_fs; rf_wr = 1'b1;
            end
            S_I_EXEC, S_LW_ADDR, S_SW_ADDR: begin
                alu_fs = FS_ADD; b_sel = 1'b1;
            end
            S_I_WB: begin
                alu_fs = FS_ADD; b_sel = 1'b1; rf_wr = 1'b1; rf_dsel = 2'b01;
            end
            S_LW_RD: begin
                alu_fs = FS_ADD; b_sel = 1'b1; dm_cs = 1'b1; dm_rd = 1'b1;
            end
            S_LW_WB: begin
                rf_wr = 1'b1; rf_dsel = 2'b01; wb_sel = 2'b01;
            end
            S_SW_WR: begin
                alu_fs = FS_ADD; b_sel = 1'b1; dm_cs = 1'b1; dm_wr = 1'b1;
            end
            S_BR_CMP:  alu_fs = FS_SUB;
            S_BR_TAKE: pc_ld = 1'b1;
            S_J: begin
                pc_ld = 1'b1; pc_sel = 2'b01;
            end
            // Link and jump share the cycle: $31 captures the pre-edge PC (already +4).
            S_JAL: begin
                rf_wr = 1'b1; rf_dsel = 2'b10; wb_sel = 2'b10; pc_ld = 1'b1; pc_sel = 2'b01;
            end
            S_JR: begin
                alu_fs = FS_PASS; pc_ld = 1'b1; pc_sel = 2'b10;
            end
            S_HALT:    halted  = 1'b1;
            S_ILLEGAL: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_control_unit.sv
module tb_mips_control_unit;

    typedef struct packed {
        logic [1:0] pc_sel;
        logic       pc_ld, pc_inc, ir_ld, im_cs, im_rd, rf_wr;
        logic [1:0] rf_dsel, wb_sel;
        logic       b_sel;
        logic [3:0] alu_fs;
        logic       dm_cs, dm_rd, dm_wr, halted, illegal;
    } ctl_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir;
    logic        alu_z;
    ctl_t        obs;

    int checks = 0;
    int errors = 0;

    mips_control_unit dut (
        .clk(clk), .reset(reset), .ir(ir), .alu_z(alu_z),
        .pc_sel(obs.pc_sel), .pc_ld(obs.pc_ld), .pc_inc(obs.pc_inc),
        .ir_ld(obs.ir_ld), .im_cs(obs.im_cs), .im_rd(obs.im_rd),
        .rf_wr(obs.rf_wr), .rf_dsel(obs.rf_dsel), .wb_sel(obs.wb_sel),
        .b_sel(obs.b_sel), .alu_fs(obs.alu_fs),
        .dm_cs(obs.dm_cs), .dm_rd(obs.dm_rd), .dm_wr(obs.dm_wr),
        .halted(obs.halted), .illegal(obs.illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: per-instruction list of the control words seen after FETCH.
    ctl_t  exp_q[$];
    ctl_t  term_w;
    bit    stop;

    function automatic ctl_t fetch_w();
        ctl_t c = '0;
        c.im_cs = 1; c.im_rd = 1; c.ir_ld = 1; c.pc_inc = 1;
        return c;
    endfunction

    function automatic void build(input logic [31:0] i, input logic z);
        ctl_t c;
        logic [5:0] op = i[31:26];
        logic [5:0] fn = i[5:0];
        logic [3:0] fs;
        exp_q.delete();
        stop = 0;
        term_w = '0;
        exp_q.push_back('0);                 // DECODE
        c = '0;
        case (op)
            6'h00: begin
                fs = 4'hF;
                if (fn == 6'h20) fs = 4'b0010;
                if (fn == 6'h22) fs = 4'b0011;
                if (fn == 6'h24) fs = 4'b1000;
                if (fn == 6'h25) fs = 4'b1001;
                if (fn == 6'h2A) fs = 4'b0110;
                if (fs != 4'hF) begin
                    c.alu_fs = fs; exp_q.push_back(c);
                    c.rf_wr = 1;   exp_q.push_back(c);
                end else if (fn == 6'h08) begin
                    c.pc_ld = 1; c.pc_sel = 2'b10; exp_q.push_back(c);
                end else if (fn == 6'h0D) begin
                    stop = 1; term_w.halted = 1;
                end else begin
                    stop = 1; term_w.illegal = 1;
                end
            end
            6'h08: begin
                c.alu_fs = 4'b0010; c.b_sel = 1; exp_q.push_back(c);
                c.rf_wr = 1; c.rf_dsel = 2'b01; exp_q.push_back(c);
            end
            6'h23: begin
                c.alu_fs = 4'b0010; c.b_sel = 1; exp_q.push_back(c);
                c.dm_cs = 1; c.dm_rd = 1; exp_q.push_back(c);
                c = '0; c.rf_wr = 1; c.rf_dsel = 2'b01; c.wb_sel = 2'b01; exp_q.push_back(c);
            end
            6'h2B: begin
                c.alu_fs = 4'b0010; c.b_sel = 1; exp_q.push_back(c);
                c.dm_cs = 1; c.dm_wr = 1; exp_q.push_back(c);
            end
            6'h04, 6'h05: begin
                c.alu_fs = 4'b0011; exp_q.push_back(c);
                if ((op == 6'h04 && z) || (op == 6'h05 && !z)) begin
                    c = '0; c.pc_ld = 1; exp_q.push_back(c);
                end
            end
            6'h02: begin
                c.pc_ld = 1; c.pc_sel = 2'b01; exp_q.push_back(c);
            end
            6'h03: begin
                c.rf_wr = 1; c.rf_dsel = 2'b10; c.wb_sel = 2'b10;
                c.pc_ld = 1; c.pc_sel = 2'b01; exp_q.push_back(c);
            end
            default: begin
                stop = 1; term_w.illegal = 1;
            end
        endcase
        if (stop) exp_q.push_back(term_w);
    endfunction

    // Called at a negedge; asserts reset asynchronously and walks through the hold cycle.
    task automatic do_reset();
        reset = 1;
        #1 chk("rst_async", obs, '0);
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_hold", obs, '0);
    endtask

    // Starts one negedge before the FETCH cycle of this instruction.
    task automatic run_instr(input logic [31:0] i, input logic z);
        @(negedge clk);
        chk("fetch", obs, fetch_w());
        ir = i; alu_z = z;
        build(i, z);
        foreach (exp_q[k]) begin
            @(negedge clk);
            chk($sformatf("ir%h_z%0d_c%0d", i, z, k + 1), obs, exp_q[k]);
        end
        if (stop) begin
            repeat (20) begin
                @(negedge clk);
                chk($sformatf("sticky_%h", i), obs, term_w);
            end
            do_reset();
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i = $urandom;
        int k = $urandom_range(0, 40);
        logic [5:0] fl [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        case (k % 10)
            0, 9: begin i[31:26] = 6'h00; i[5:0] = fl[$urandom_range(0, 4)]; end
            1: i[31:26] = 6'h08;
            2: i[31:26] = 6'h23;
            3: i[31:26] = 6'h2B;
            4: i[31:26] = 6'h04;
            5: i[31:26] = 6'h05;
            6: i[31:26] = 6'h02;
            7: i[31:26] = 6'h03;
            default: begin i[31:26] = 6'h00; i[5:0] = 6'h08; end
        endcase
        if (k == 40) begin i[31:26] = 6'h00; i[5:0] = 6'h0D; end
        if (k == 39) i[31:26] = 6'h3F;
        if (k == 38) begin i[31:26] = 6'h00; i[5:0] = 6'h21; end
        return i;
    endfunction

    initial begin
        reset = 1; ir = '0; alu_z = 0;
        repeat (2) @(negedge clk);
        chk("reset_state", obs, '0);
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("reset_hold", obs, '0);

        run_instr(32'h012A4020, 0);  // add
        run_instr(32'h8D090004, 1);  // lw
        run_instr(32'hAD090004, 0);  // sw
        run_instr(32'h1109FFFE, 1);  // beq taken
        run_instr(32'h1109FFFE, 0);  // beq not taken
        run_instr(32'h1509FFFE, 0);  // bne taken
        run_instr(32'h1509FFFE, 1);  // bne not taken
        run_instr(32'h0C000010, 0);  // jal
        run_instr(32'h03E00008, 0);  // jr $31
        run_instr(32'h2128FFFF, 0);  // addi

        // Reset landing in the middle of LW_RD.
        @(negedge clk);
        chk("abort_fetch", obs, fetch_w());
        ir = 32'h8D090004;
        build(ir, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort_c%0d", k + 1), obs, exp_q[k]);
        end
        do_reset();

        run_instr(32'h0000000D, 0);  // halt
        run_instr(32'hFC000000, 0);  // illegal opcode
        run_instr(32'h012A4020, 1);  // normal again after reset

        for (int n = 0; n < 300; n++) run_instr(rand_instr(), 1'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_control_unit.md
Name: mips_control_unit

Overview:
- Multicycle control FSM for the enhanced MIPS processor. It sits directly downstream of the instruction unit.
- Consumes the instruction register (IR) contents and the ALU zero flag.
- Drives the instruction unit's PC, IR and instruction-memory controls, plus register-file, ALU and data-memory controls.
- Sequences fetch, decode, execute and writeback for the supported instruction subset.

Parameters:
- RA_REG, 5'd31, register index written by jal.
- RESET_HOLD, 1, cycles spent in state RESET after reset release before the first FETCH (≥1).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- ir  input  32  current IR contents from the instruction unit.
- alu_z  input  1  ALU zero flag; valid during BR_CMP.
- pc_sel  output  2  PC source: 00 branch, 01 jump, 10 PC_in (register).
- pc_ld  output  1  load PC from the pc_sel source.
- pc_inc  output  1  PC <= PC+4.
- ir_ld  output  1  IR <= instruction memory output.
- im_cs  output  1  instruction memory chip select.
- im_rd  output  1  instruction memory read.
- rf_wr  output  1  register file write enable.
- rf_dsel  output  2  write-address select: 00 rd, 01 rt, 10 RA_REG.
- wb_sel  output  2  write-data select: 00 ALU result, 01 data memory, 10 PC.
- b_sel  output  1  ALU B operand: 0 rt, 1 sign-extended immediate.
- alu_fs  output  4  0000 PASS_S, 0010 ADD, 0011 SUB, 0110 SLT, 1000 AND, 1001 OR.
- dm_cs, dm_rd, dm_wr  output  1 each  data memory controls.
- halted  output  1  set in HALT.
- illegal  output  1  set in ILLEGAL.

Behaviour:
- Reset: async, to state RESET. All outputs are 0 immediately, including mid-instruction. After reset deasserts, FSM stays in RESET for RESET_HOLD posedges, then enters FETCH.
- Default for every output in every state is 0. Each state asserts only what is listed.
- FETCH: im_cs=im_rd=ir_ld=pc_inc=1. At the edge, IR captures mem[PC] and PC becomes PC+4. Next state: DECODE.
- DECODE: no outputs. Dispatch on ir[31:26] and funct ir[5:0]:
  - 000000 with funct 20/22/24/25/2A: R_EXEC.
  - 000000 with funct 08: JR.
  - 000000 with funct 0D: HALT.
  - 08: I_EXEC. 23: LW_ADDR. 2B: SW_ADDR. 04/05: BR_CMP. 02: J. 03: JAL.
  - Anything else: ILLEGAL.
- R_EXEC: alu_fs from funct (20 ADD, 22 SUB, 24 AND, 25 OR, 2A SLT), b_sel=0. Next: R_WB.
- R_WB: alu_fs held, rf_wr=1, rf_dsel=00, wb_sel=00. Next: FETCH.
- I_EXEC (addi): alu_fs=ADD, b_sel=1. Next: I_WB.
- I_WB: alu_fs=ADD, b_sel=1, rf_wr=1, rf_dsel=01. Next: FETCH.
- LW_ADDR: ADD, b_sel=1. Next: LW_RD.
- LW_RD: ADD, b_sel=1, dm_cs=dm_rd=1. Next: LW_WB.
- LW_WB: rf_wr=1, rf_dsel=01, wb_sel=01. Next: FETCH.
- SW_ADDR: ADD, b_sel=1. Next: SW_WR.
- SW_WR: ADD, b_sel=1, dm_cs=dm_wr=1. Next: FETCH.
- BR_CMP: alu_fs=SUB, b_sel=0. Branch is taken when (beq and alu_z=1) or (bne and alu_z=0).
  - Taken: BR_TAKE.
  - Not taken: FETCH.
- BR_TAKE: pc_ld=1, pc_sel=00. Target = incremented PC + (SE imm << 2). Next: FETCH.
- J: pc_ld=1, pc_sel=01. Next: FETCH.
- JAL: rf_wr=1, rf_dsel=10, wb_sel=10, pc_ld=1, pc_sel=01, all in one cycle. $31 receives the already-incremented PC (the pre-edge value). Next: FETCH.
- JR: alu_fs=PASS_S, pc_ld=1, pc_sel=10. Next: FETCH.
- HALT: halted=1. Sticky until reset; no memory access, no PC change.
- ILLEGAL: illegal=1. Sticky until reset.
- Invariants:
  - pc_ld and pc_inc are never both 1.
  - dm_rd and dm_wr are never both 1.
  - rf_wr is asserted only in R_WB, I_WB, LW_WB and JAL.
- Cycle counts (FETCH through the last state):
  - 3: J, JR, JAL, not-taken branch.
  - 4: R-type, addi, sw, taken branch.
  - 5: lw.
- ir is sampled only in DECODE and later states of the same instruction. It is stable there because ir_ld=0 outside FETCH.

Test Plan:
- Reset with RESET_HOLD=1: assert reset mid-LW_RD → all outputs 0 in the same cycle. Release → one RESET cycle, then FETCH with im_cs=im_rd=ir_ld=pc_inc=1.
- ir=0x012A4020 (add $8,$9,$10) → sequence FETCH, DECODE, R_EXEC(alu_fs=0010), R_WB(rf_wr=1, rf_dsel=00), FETCH; 4 cycles.
- ir=0x8D090004 (lw): LW_RD shows dm_cs=dm_rd=1; LW_WB shows wb_sel=01, rf_dsel=01. ir=0xAD090004 (sw): SW_WR shows dm_wr=1, rf_wr=0 throughout.
- ir=0x1109FFFE (beq): with alu_z=1 → BR_TAKE pc_ld=1, pc_sel=00. Repeat with alu_z=0 → straight to FETCH. For bne (0x1509FFFE) with alu_z=0 → taken.
- ir=0x0C000010 (jal) → one cycle with rf_wr=1, rf_dsel=10, wb_sel=10, pc_ld=1, pc_sel=01. ir=0x03E00008 (jr $31) → pc_sel=10, pc_ld=1.
- ir=0x0000000D → halted=1 held for 20 cycles, im_cs=0. ir=0xFC000000 → illegal=1 sticky. Both clear only on reset.
